// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: read-owner tags, arbiter states
// and the width of the starvation/burst counters.
package dmem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    typedef enum logic {
        ARB_CPU   = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// 4-bit saturating counter: clear wins over increment, and the count stops at
// limit_i instead of wrapping.
module arb_sat_counter
    import dmem_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU memory stage and the DMA
// streamer, with bounded starvation both ways and one-cycle read-return routing.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic        cpu_wait,
    output logic [31:0] cpu_q,
    output logic        cpu_qvalid,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic        dma_wren,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_data,
    output logic        dma_gnt,
    output logic [31:0] dma_q,
    output logic        dma_qvalid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(MAX_BURST);

    arb_state_e       state_q, state_d;
    owner_e           rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0] starve_cnt, burst_cnt;
    logic             cpu_gnt, dma_gnt_c;
    logic             starve_clr, starve_inc, burst_clr, burst_inc, max_exit;

    arb_sat_counter u_starve_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (starve_clr),
        .inc_i   (starve_inc),
        .limit_i (STARVE_LIM),
        .cnt_o   (starve_cnt)
    );

    arb_sat_counter u_burst_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (burst_clr),
        .inc_i   (burst_inc),
        .limit_i (BURST_LIM),
        .cnt_o   (burst_cnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_CPU;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu_gnt   = 1'b0;
        dma_gnt_c = 1'b0;
        burst_clr = 1'b0;
        burst_inc = 1'b0;
        max_exit  = 1'b0;
        case (state_q)
            ARB_CPU: begin
                if (dma_req && (!cpu_req || (starve_cnt == STARVE_LIM))) begin
                    dma_gnt_c = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end
                // burst_cnt sits at 0 in ARB_CPU, so the entry grant loads it with 1
                if (dma_gnt_c && dma_lock) begin
                    state_d   = ARB_BURST;
                    burst_inc = 1'b1;
                end else begin
                    burst_clr = 1'b1;
                end
            end
            ARB_BURST: begin
                if (dma_req && dma_lock && (burst_cnt < BURST_LIM)) begin
                    dma_gnt_c = 1'b1;
                    burst_inc = 1'b1;
                end else begin
                    state_d   = ARB_CPU;
                    burst_clr = 1'b1;
                    max_exit  = (burst_cnt == BURST_LIM);
                    if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt_c = 1'b1;
                    end
                end
            end
        endcase
        // a forced CPU cycle after a full burst must not count against the DMA
        starve_clr = dma_gnt_c || !dma_req || max_exit;
        starve_inc = dma_req && !dma_gnt_c;
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_data = cpu_data;
            mem_wren = cpu_wren;
        end else if (dma_gnt_c) begin
            mem_addr = dma_addr;
            mem_data = dma_data;
            mem_wren = dma_wren;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (cpu_gnt && !cpu_wren) begin
            rd_owner_d = OWN_CPU;
        end else if (dma_gnt_c && !dma_wren) begin
            rd_owner_d = OWN_DMA;
        end
    end

    assign cpu_wait   = !reset && cpu_req && !cpu_gnt;
    assign dma_gnt    = !reset && dma_gnt_c;
    assign cpu_qvalid = (rd_owner_q == OWN_CPU);
    assign dma_qvalid = (rd_owner_q == OWN_DMA);
    assign cpu_q      = cpu_qvalid ? mem_q : '0;
    assign dma_q      = dma_qvalid ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a read-return scoreboard and
// hand-written reset-in-flight sequences.
module tb_dmem_arbiter;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_CPU  = 2'd1;
    localparam logic [1:0] G_DMA  = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_wren = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_data = '0;
    logic        cpu_wait, cpu_qvalid;
    logic [31:0] cpu_q;
    logic        dma_req = 1'b0, dma_lock = 1'b0, dma_wren = 1'b0;
    logic [31:0] dma_addr = '0, dma_data = '0;
    logic        dma_gnt, dma_qvalid;
    logic [31:0] dma_q;
    logic [31:0] mem_addr, mem_data;
    logic        mem_wren;
    logic [31:0] mem_q = '0;

    dmem_arbiter #(.STARVE_LIMIT(4), .MAX_BURST(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wren   (cpu_wren),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_wait   (cpu_wait),
        .cpu_q      (cpu_q),
        .cpu_qvalid (cpu_qvalid),
        .dma_req    (dma_req),
        .dma_lock   (dma_lock),
        .dma_wren   (dma_wren),
        .dma_addr   (dma_addr),
        .dma_data   (dma_data),
        .dma_gnt    (dma_gnt),
        .dma_q      (dma_q),
        .dma_qvalid (dma_qvalid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return a ^ 32'hC3C3_0000;
    endfunction

    // synchronous memory: data for the address presented at an edge appears after it
    always @(posedge clock) mem_q <= memf(mem_addr);

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dl, dw;
        logic [31:0] da, dd;
        logic        ew;
        logic [1:0]  eg;
    } vec_t;

    typedef struct {
        logic [1:0]  own;
        logic [31:0] data;
    } ret_t;

    vec_t vecs[$];
    ret_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic v(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dl, input logic dw, input logic [31:0] da,
                     input logic [31:0] dd, input logic ew, input logic [1:0] eg);
        vec_t t;
        t.cr = cr; t.cw = cw; t.ca = ca; t.cd = cd;
        t.dr = dr; t.dl = dl; t.dw = dw; t.da = da; t.dd = dd;
        t.ew = ew; t.eg = eg;
        vecs.push_back(t);
    endtask

    task automatic idle();
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, G_NONE);
    endtask

    task automatic drive(input vec_t t);
        cpu_req = t.cr; cpu_wren = t.cw; cpu_addr = t.ca; cpu_data = t.cd;
        dma_req = t.dr; dma_lock = t.dl; dma_wren = t.dw; dma_addr = t.da; dma_data = t.dd;
    endtask

    task automatic check_return(input string tag);
        ret_t r;
        r.own = G_NONE;
        r.data = '0;
        if (sb.size() > 0) r = sb.pop_front();
        chk({tag, " cpu_qvalid"}, 32'(cpu_qvalid), 32'(r.own == G_CPU));
        chk({tag, " dma_qvalid"}, 32'(dma_qvalid), 32'(r.own == G_DMA));
        chk({tag, " cpu_q"}, cpu_q, (r.own == G_CPU) ? r.data : 32'h0);
        chk({tag, " dma_q"}, dma_q, (r.own == G_DMA) ? r.data : 32'h0);
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        string       tag;
        logic [31:0] ea, ed;
        logic        ewr;
        ret_t        r;
        tag = $sformatf("v%0d", idx);
        @(negedge clock);
        drive(t);
        #1;
        ea = '0; ed = '0; ewr = 1'b0;
        if (t.eg == G_CPU) begin
            ea = t.ca; ed = t.cd; ewr = t.cw;
        end else if (t.eg == G_DMA) begin
            ea = t.da; ed = t.dd; ewr = t.dw;
        end
        chk({tag, " cpu_wait"}, 32'(cpu_wait), 32'(t.ew));
        chk({tag, " dma_gnt"}, 32'(dma_gnt), 32'(t.eg == G_DMA));
        chk({tag, " mem_addr"}, mem_addr, ea);
        chk({tag, " mem_wren"}, 32'(mem_wren), 32'(ewr));
        chk({tag, " mem_data"}, mem_data, ed);
        check_return(tag);
        r.own = (t.eg != G_NONE && !ewr) ? t.eg : G_NONE;
        r.data = memf(ea);
        sb.push_back(r);
    endtask

    initial begin
        // reset state with idle inputs
        repeat (2) @(negedge clock);
        #1;
        chk("rst cpu_wait", 32'(cpu_wait), 0);
        chk("rst dma_gnt", 32'(dma_gnt), 0);
        chk("rst cpu_qvalid", 32'(cpu_qvalid), 0);
        chk("rst dma_qvalid", 32'(dma_qvalid), 0);
        chk("rst cpu_q", cpu_q, 0);
        chk("rst dma_q", dma_q, 0);
        chk("rst mem_wren", 32'(mem_wren), 0);
        @(negedge clock);
        reset = 1'b0;

        // single CPU read, then CPU write
        v(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, G_CPU);
        idle();
        v(1, 1, 32'h20, 32'h5, 0, 0, 0, 0, 0, 0, G_CPU);
        idle();
        // starvation: CPU wins four times, DMA forced on the fifth
        for (int i = 0; i < 4; i++)
            v(1, 0, 32'h100 + i, 0, 1, 0, 0, 32'h800 + i, 0, 0, G_CPU);
        v(1, 0, 32'h104, 0, 1, 0, 0, 32'h804, 0, 1, G_DMA);
        v(1, 0, 32'h105, 0, 1, 0, 0, 32'h805, 0, 0, G_CPU);
        idle();
        // alternating single-requester reads
        v(1, 0, 32'h110, 0, 0, 0, 0, 0, 0, 0, G_CPU);
        v(0, 0, 0, 0, 1, 0, 0, 32'h810, 0, 0, G_DMA);
        v(1, 0, 32'h111, 0, 0, 0, 0, 0, 0, 0, G_CPU);
        v(0, 0, 0, 0, 1, 0, 0, 32'h811, 0, 0, G_DMA);
        idle();
        // locked burst won via starvation: 8 DMA grants, then CPU
        for (int i = 0; i < 4; i++)
            v(1, 0, 32'h120 + i, 0, 1, 1, 0, 32'h820 + i, 0, 0, G_CPU);
        v(1, 0, 32'h124, 0, 1, 1, 0, 32'h824, 0, 1, G_DMA);
        for (int i = 0; i < 7; i++)
            v(1, 0, 32'h124, 0, 1, 1, 0, 32'h825 + i, 0, 1, G_DMA);
        v(1, 0, 32'h130, 0, 1, 1, 0, 32'h82F, 0, 0, G_CPU);
        v(1, 0, 32'h131, 0, 1, 1, 0, 32'h830, 0, 0, G_CPU);
        idle();
        // burst exits: unlock hands DMA an unlocked grant, dropped req hands CPU
        v(0, 0, 0, 0, 1, 1, 0, 32'h840, 0, 0, G_DMA);
        v(1, 0, 32'h140, 0, 1, 1, 1, 32'h841, 32'h77, 1, G_DMA);
        v(0, 0, 0, 0, 1, 0, 0, 32'h842, 0, 0, G_DMA);
        v(0, 0, 0, 0, 1, 1, 0, 32'h843, 0, 0, G_DMA);
        v(1, 0, 32'h141, 0, 0, 0, 0, 0, 0, 0, G_CPU);
        idle();

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // reset between a DMA read grant and its return edge
        @(negedge clock);
        cpu_req = 0; dma_req = 1; dma_lock = 0; dma_wren = 0; dma_addr = 32'h900;
        #1;
        chk("rdrop gnt", 32'(dma_gnt), 1);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rdrop in-reset dma_qvalid", 32'(dma_qvalid), 0);
        chk("rdrop in-reset dma_gnt", 32'(dma_gnt), 0);
        @(negedge clock);
        reset = 1'b0;
        dma_req = 0;
        sb.delete();
        #1;
        chk("rdrop dma_qvalid", 32'(dma_qvalid), 0);
        chk("rdrop dma_q", dma_q, 0);

        // reset inside a locked burst: CPU priority afterwards
        @(negedge clock);
        dma_req = 1; dma_lock = 1; dma_addr = 32'h910;
        #1;
        chk("babort gnt", 32'(dma_gnt), 1);
        @(negedge clock);
        #1;
        chk("babort burst gnt", 32'(dma_gnt), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cpu_req = 1; cpu_addr = 32'h150;
        #1;
        chk("babort cpu_wait", 32'(cpu_wait), 0);
        chk("babort dma_gnt", 32'(dma_gnt), 0);
        chk("babort mem_addr", mem_addr, 32'h150);
        @(negedge clock);
        cpu_req = 0; dma_req = 0; dma_lock = 0;
        #1;
        chk("babort cpu_qvalid", 32'(cpu_qvalid), 1);
        chk("babort cpu_q", cpu_q, memf(32'h150));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the processor's single data-memory port between the processor's memory-stage access and a DMA requester (audio sample streamer). Chooses one owner per cycle, routes the synchronous one-cycle read data back to whichever requester issued the read, and bounds starvation in both directions. It sits between the processor's dmem outputs and the dmem instance in the wrapper. Its `cpu_wait` output feeds the stall controller.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied DMA request cycles before the DMA is forced a grant (valid range 1-15).
- `MAX_BURST`, default 8: maximum consecutive locked DMA grants before one CPU cycle is forced (valid range 1-15).
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` in 1: CPU memory access this cycle.
- `cpu_wren` in 1: CPU access is a write.
- `cpu_addr` in 32: CPU address.
- `cpu_data` in 32: CPU write data.
- `cpu_wait` out 1: CPU request not granted this cycle.
- `cpu_q` out 32: read data to CPU.
- `cpu_qvalid` out 1: `cpu_q` valid.
- `dma_req` in 1: DMA request.
- `dma_lock` in 1: DMA requests a back-to-back burst.
- `dma_wren` in 1: DMA write.
- `dma_addr` in 32: DMA address.
- `dma_data` in 32: DMA write data.
- `dma_gnt` out 1: DMA granted this cycle.
- `dma_q` out 32: read data to DMA.
- `dma_qvalid` out 1: `dma_q` valid.
- `mem_addr` out 32: to dmem address.
- `mem_data` out 32: to dmem write data.
- `mem_wren` out 1: to dmem write enable.
- `mem_q` in 32: dmem read data, valid one cycle after address.

## Operation
- **States:** `ARB_CPU` (CPU priority, reset state) and `ARB_BURST` (DMA owns port).
- **`ARB_CPU` grant rules:**
  - Only one requester: that requester is granted.
  - Both requesting: CPU wins unless `starve_cnt == STARVE_LIMIT`, in which case DMA wins and `cpu_wait=1`.
- **Starvation counter** (saturating at `STARVE_LIMIT`):
  - `starve_cnt` +1 when `dma_req && !dma_gnt`.
  - Cleared when `dma_gnt` is set or `dma_req` is low.
- **Entering a burst:** a DMA grant with `dma_lock=1` moves `ARB_CPU` to `ARB_BURST`. `burst_cnt` is loaded with 1.
- **`ARB_BURST` behaviour:**
  - DMA is granted while `dma_req && dma_lock && burst_cnt < MAX_BURST`. `burst_cnt` +1 per grant.
  - `cpu_wait = cpu_req`.
- **Leaving a burst:**
  - Exit to `ARB_CPU` when `dma_req=0`, `dma_lock=0`, or `burst_cnt == MAX_BURST`.
  - On the exit cycle the port goes to the CPU if `cpu_req=1`, otherwise to the DMA if still requesting. The DMA case is an unlocked grant.
  - After a `MAX_BURST` exit, `starve_cnt` is held at 0 for that cycle.
- **Memory mux:** `mem_addr`/`mem_data`/`mem_wren` are driven combinationally from the granted requester. With no grant: `mem_wren=0`, addr/data 0.
- **Read tracking:** a granted read (`wren=0`) sets the registered `rd_owner` to CPU or DMA, otherwise NONE.
- **Read return:** next cycle, `cpu_q`/`dma_q` = `mem_q` and the matching `qvalid=1`. The other `q` output is held at 0.
- **Writes:** produce no `qvalid`.

## Timing
- Grant decision is combinational; 0-cycle request-to-memory latency.
- Read data returns exactly 1 cycle after grant.
- **Reset values:**
  - All outputs 0 except `mem_*`, which follow the mux.
  - During reset, state=`ARB_CPU`, `starve_cnt=0`, `burst_cnt=0`, `rd_owner=NONE`.
- **Reset mid-operation:** a pending read return is dropped (`qvalid` stays 0) and any burst is abandoned.
- **Worst-case waits:**
  - CPU waits at most `MAX_BURST` consecutive cycles.
  - DMA waits at most `STARVE_LIMIT` cycles.
- **Simultaneous read return and new grant:** the return uses `rd_owner` from the previous cycle. The new grant updates it for the following cycle; back-to-back reads pipeline with no bubble.
- **Counter widths:** 4 bits, saturating, never wrapping.

## Structure
- **Shared package `dmem_arb_pkg`:**
  - Owner encoding: `OWN_NONE=2'd0`, `OWN_CPU=2'd1`, `OWN_DMA=2'd2`.
  - State encoding: `ARB_CPU=1'b0`, `ARB_BURST=1'b1`.
- **Sub-module `arb_sat_counter`:** 4-bit saturating counter with `clear`, `inc` and a limit input. Instantiated twice: starvation and burst.

## Test plan
- CPU-only read of addr 0x10 with `mem_q=0xDEADBEEF` → `mem_addr=0x10`, `cpu_wait=0`; next cycle `cpu_qvalid=1`, `cpu_q=0xDEADBEEF`, `dma_qvalid=0`.
- Both requesting continuously, `STARVE_LIMIT=4` → CPU granted 4 cycles, DMA granted on the 5th with `cpu_wait=1`, then CPU again.
- DMA locked burst with `cpu_req` held, `MAX_BURST=8` → 8 DMA grants, `cpu_wait=1` for 8 cycles, 9th cycle CPU granted.
- Alternating CPU read / DMA read every cycle → returns land on the correct `qvalid` each cycle with no bubble or swap.
- CPU write of 0x5 to addr 0x20 → `mem_wren=1`, `mem_data=0x5`; no `qvalid` next cycle.
- DMA read granted, reset asserted before the return edge → `dma_qvalid=0` and state=`ARB_CPU` after release.
